hazard_ctrl: RTL and testbench

//   Pipeline hazard and stall sequencer for the 5-stage MIPS core. Compares D-stage source

---
 rtl/hazard_ctrl.sv | 90 +++++++++
 tb/tb_hazard_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall sequencer: Tuse/Tnew register hazards, mult/div busy
// tracking, and the single stall decision driving fetch hold, D hold and E bubble.
//
// state | meaning
// IDLE  | mult/div unit free, waiting for a start in E
// BUSY  | mult/div in progress, cnt counts down remaining cycles
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic [1:0]       D_tuse_rs,
  input  logic [1:0]       D_tuse_rt,
  input  logic             D_is_md,
  input  logic [4:0]       E_waddr,
  input  logic [1:0]       E_tnew,
  input  logic [4:0]       M_waddr,
  input  logic [1:0]       M_tnew,
  input  logic             E_md_start,
  input  logic             E_md_div,
  output logic             stop_sel,
  output logic             D_en,
  output logic             E_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC - 1);

  md_state_t  state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       stall_rs, stall_rt, stall_md, stall;

  // A nonzero source register implicitly excludes waddr==0 from matching.
  always_comb begin
    stall_rs = (D_rs != 5'd0) && (D_tuse_rs != 2'd3) &&
               (((E_waddr == D_rs) && (E_tnew > D_tuse_rs)) ||
                ((M_waddr == D_rs) && (M_tnew > D_tuse_rs)));
    stall_rt = (D_rt != 5'd0) && (D_tuse_rt != 2'd3) &&
               (((E_waddr == D_rt) && (E_tnew > D_tuse_rt)) ||
                ((M_waddr == D_rt) && (M_tnew > D_tuse_rt)));
    stall_md = D_is_md && (md_busy || E_md_start);
    stall    = stall_rs || stall_rt || stall_md;
  end

  assign md_busy  = (state == BUSY);
  assign stop_sel = stall;
  assign D_en     = ~stall;
  assign E_flush  = stall;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (E_md_start) begin
          state_nxt = BUSY;
          cnt_nxt   = E_md_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        // A start pulse seen here is ignored: no reload, no restart.
        if (cnt == 4'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      stall_count <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (stall && !(&stall_count))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl, built with CNT_W=4 so the
// saturating stall counter can be exercised in a few dozen cycles.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] D_rs = '0, D_rt = '0, E_waddr = '0, M_waddr = '0;
  logic [1:0] D_tuse_rs = 2'd3, D_tuse_rt = 2'd3, E_tnew = '0, M_tnew = '0;
  logic       D_is_md = 1'b0, E_md_start = 1'b0, E_md_div = 1'b0;
  logic       stop_sel, D_en, E_flush, md_busy;
  logic [3:0] stall_count;

  int n_checks = 0;
  int n_errors = 0;

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_is_md(D_is_md), .E_waddr(E_waddr), .E_tnew(E_tnew),
    .M_waddr(M_waddr), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_div(E_md_div),
    .stop_sel(stop_sel), .D_en(D_en), .E_flush(E_flush),
    .md_busy(md_busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    D_rs = '0; D_rt = '0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3; D_is_md = 1'b0;
    E_waddr = '0; E_tnew = '0; M_waddr = '0; M_tnew = '0;
    E_md_start = 1'b0; E_md_div = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Inputs already applied; settle, check the three stall outputs, then clock.
  task automatic vec(input string tag, input logic exp_stall);
    #1;
    chk({tag, ".stop_sel"}, 32'(stop_sel), 32'(exp_stall));
    chk({tag, ".D_en"},     32'(D_en),     32'(!exp_stall));
    chk({tag, ".E_flush"},  32'(E_flush),  32'(exp_stall));
    tick();
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst.md_busy", 32'(md_busy), 0);
    chk("rst.stall_count", 32'(stall_count), 0);
    vec("rst", 1'b0);

    // Register hazards
    idle(); E_waddr = 5'd1; E_tnew = 2'd2; D_rs = 5'd1; D_tuse_rs = 2'd1;
    vec("lw_use_e", 1'b1);
    chk("lw_use.count", 32'(stall_count), 1);
    idle(); vec("after_lw", 1'b0);
    idle(); E_waddr = 5'd1; E_tnew = 2'd2; D_rs = 5'd0; D_tuse_rs = 2'd1;
    vec("rs_zero", 1'b0);
    idle(); E_waddr = 5'd0; E_tnew = 2'd2; M_waddr = 5'd0; M_tnew = 2'd2;
    D_rs = 5'd0; D_tuse_rs = 2'd0; D_rt = 5'd0; D_tuse_rt = 2'd0;
    vec("r0_big_tnew", 1'b0);
    idle(); E_waddr = 5'd1; E_tnew = 2'd2; D_rs = 5'd1; D_tuse_rs = 2'd3;
    vec("rs_not_read", 1'b0);
    idle(); M_waddr = 5'd1; M_tnew = 2'd1; D_rs = 5'd1; D_tuse_rs = 2'd0;
    vec("m_match", 1'b1);
    idle(); M_waddr = 5'd1; M_tnew = 2'd1; D_rs = 5'd1; D_tuse_rs = 2'd1;
    vec("m_tnew_eq_tuse", 1'b0);
    idle(); E_waddr = 5'd7; E_tnew = 2'd0; D_rs = 5'd7; D_tuse_rs = 2'd0;
    vec("tnew0", 1'b0);
    idle(); E_waddr = 5'd5; E_tnew = 2'd1; D_rt = 5'd5; D_tuse_rt = 2'd0;
    vec("rt_e_match", 1'b1);
    idle(); E_waddr = 5'd2; E_tnew = 2'd1; M_waddr = 5'd2; M_tnew = 2'd2;
    D_rs = 5'd2; D_tuse_rs = 2'd1;
    vec("both_m_qual", 1'b1);
    idle(); E_waddr = 5'd3; E_tnew = 2'd2; D_rs = 5'd4; D_rt = 5'd6;
    D_tuse_rs = 2'd0; D_tuse_rt = 2'd0;
    vec("no_match", 1'b0);
    chk("hazard.count", 32'(stall_count), 4);

    // Mult: start cycle plus 5 busy cycles stall a dependent md instruction
    do_reset();
    E_md_start = 1'b1; E_md_div = 1'b0; D_is_md = 1'b1;
    #1;
    chk("mult.c0.md_busy", 32'(md_busy), 0);
    vec("mult.c0", 1'b1);
    E_md_start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      #1;
      chk($sformatf("mult.c%0d.md_busy", i), 32'(md_busy), 32'(i <= 5));
      vec($sformatf("mult.c%0d", i), 1'(i <= 5));
    end
    chk("mult.count", 32'(stall_count), 6);

    // Div: 10 busy cycles, a second start at cycle 3 is ignored
    do_reset();
    E_md_start = 1'b1; E_md_div = 1'b1;
    tick();
    E_md_start = 1'b0; E_md_div = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      E_md_start = (i == 3);
      #1;
      chk($sformatf("div.c%0d.md_busy", i), 32'(md_busy), 32'(i <= 10));
      tick();
    end
    E_md_start = 1'b0;
    chk("div.count", 32'(stall_count), 0);

    // Reset in the middle of a busy period
    do_reset();
    E_md_start = 1'b1; E_md_div = 1'b1;
    tick();
    E_md_start = 1'b0; E_md_div = 1'b0; D_is_md = 1'b1;
    tick();
    tick();
    #1;
    chk("rstbusy.pre.md_busy", 32'(md_busy), 1);
    chk("rstbusy.pre.count", 32'(stall_count), 2);
    idle();
    reset = 1'b1;
    tick();
    chk("rstbusy.md_busy", 32'(md_busy), 0);
    chk("rstbusy.count", 32'(stall_count), 0);
    chk("rstbusy.D_en", 32'(D_en), 1);
    reset = 1'b0;
    D_is_md = 1'b1;
    vec("rstbusy.after", 1'b0);
    chk("rstbusy.after.md_busy", 32'(md_busy), 0);

    // Saturation of the 4-bit stall counter
    do_reset();
    E_waddr = 5'd1; E_tnew = 2'd2; D_rs = 5'd1; D_tuse_rs = 2'd0;
    for (int i = 1; i <= 19; i++) begin
      tick();
      if (i == 14) chk("sat.14", 32'(stall_count), 14);
      if (i == 15) chk("sat.15", 32'(stall_count), 15);
    end
    chk("sat.19", 32'(stall_count), 15);
    chk("sat.stop_sel", 32'(stop_sel), 1);
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
